// File: rtl/fp_toplama_hakem.sv
`default_nettype none
// ============================================================================
// Module      : fp_toplama_hakem
// Description : Round-robin arbiter/sequencer sharing one fp_toplama
//               floating-point adder between N requesters. Accepts operand
//               pairs over valid/ready handshakes, drives the adder enable and
//               operands, waits for the adder's done strobe under a watchdog,
//               and returns the sum tagged with the owning requester ID.
//               Every operation ends with a one-cycle enable drop so the adder
//               clears its internal state before the next operation.
// Ports       :
//   clk_i, rst_ni            clock (rising edge), async active-low reset
//   req_valid_i/req_ready_o  per-requester handshake (ready is one-hot/zero)
//   req_g1_i/req_g2_i        packed operands, requester k at [k*b +: b]
//   add_en_o, add_g1_o/g2_o  adder enable and operands
//   add_done_i, add_toplam_i adder result strobe and sum
//   res_valid_o/res_ready_i  result handshake
//   res_toplam_o, res_id_o   result sum and owner ID
//   res_err_o                adder timed out (sum forced to 0)
//   busy_o                   sequencer not idle
// Revision    : 1.0 - initial release
// ============================================================================
module fp_toplama_hakem #(
    parameter int b       = 32,
    parameter int N       = 4,
    parameter int IDW     = 2,
    parameter int TIMEOUT = 16
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic [N-1:0]   req_valid_i,
    output logic [N-1:0]   req_ready_o,
    input  logic [N*b-1:0] req_g1_i,
    input  logic [N*b-1:0] req_g2_i,
    output logic           add_en_o,
    output logic [b-1:0]   add_g1_o,
    output logic [b-1:0]   add_g2_o,
    input  logic           add_done_i,
    input  logic [b-1:0]   add_toplam_i,
    output logic           res_valid_o,
    input  logic           res_ready_i,
    output logic [b-1:0]   res_toplam_o,
    output logic [IDW-1:0] res_id_o,
    output logic           res_err_o,
    output logic           busy_o
);

    // Counter only has to reach TIMEOUT-1.
    localparam int                 c_cnt_w   = $clog2(TIMEOUT);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_RESP    = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    state_t             state_q,  state_d;
    logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [c_cnt_w-1:0] cnt_q,    cnt_d;
    logic [b-1:0]       g1_q,     g1_d;
    logic [b-1:0]       g2_q,     g2_d;
    logic [IDW-1:0]     id_q,     id_d;
    logic [b-1:0]       sum_q,    sum_d;
    logic               err_q,    err_d;

    logic [N-1:0]       w_grant_oh;
    logic [IDW-1:0]     w_grant_idx;
    logic               w_grant_vld;
    logic [b-1:0]       w_sel_g1;
    logic [b-1:0]       w_sel_g2;

    // (p + off) mod N for off in [0, N]; p is always < N.
    function automatic logic [IDW-1:0] wrap_inc(input logic [IDW-1:0] p, input int off);
        int s;
        s = int'(p) + off;
        if (s >= N) begin
            s = s - N;
        end
        return s[IDW-1:0];
    endfunction

    // Round-robin pick: first valid requester starting at rr_ptr_q.
    always_comb begin
        w_grant_oh  = '0;
        w_grant_idx = '0;
        w_grant_vld = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!w_grant_vld && req_valid_i[wrap_inc(rr_ptr_q, i)]) begin
                w_grant_vld = 1'b1;
                w_grant_idx = wrap_inc(rr_ptr_q, i);
            end
        end
        if (w_grant_vld) begin
            w_grant_oh[w_grant_idx] = 1'b1;
        end
    end

    // Operand mux driven by the one-hot grant.
    always_comb begin
        w_sel_g1 = '0;
        w_sel_g2 = '0;
        for (int k = 0; k < N; k++) begin
            if (w_grant_oh[k]) begin
                w_sel_g1 = req_g1_i[k*b +: b];
                w_sel_g2 = req_g2_i[k*b +: b];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            rr_ptr_q <= '0;
            cnt_q    <= '0;
            g1_q     <= '0;
            g2_q     <= '0;
            id_q     <= '0;
            sum_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
            g1_q     <= g1_d;
            g2_q     <= g2_d;
            id_q     <= id_d;
            sum_q    <= sum_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        cnt_d        = cnt_q;
        g1_d         = g1_q;
        g2_d         = g2_q;
        id_d         = id_q;
        sum_d        = sum_q;
        err_d        = err_q;

        // Ready is also masked by reset so every output reads 0 while
        // rst_ni is low, even if requesters keep their valids up.
        req_ready_o  = '0;
        add_en_o     = 1'b0;
        add_g1_o     = g1_q;
        add_g2_o     = g2_q;
        res_valid_o  = 1'b0;
        res_toplam_o = '0;
        res_id_o     = '0;
        res_err_o    = 1'b0;
        busy_o       = 1'b1;

        case (state_q)
            S_IDLE: begin
                busy_o   = 1'b0;
                add_g1_o = '0;
                add_g2_o = '0;
                if (rst_ni) begin
                    req_ready_o = w_grant_oh;
                end
                // Ready is raised for the granted requester whenever it is
                // valid, so a valid grant is the handshake itself.
                if (w_grant_vld) begin
                    g1_d     = w_sel_g1;
                    g2_d     = w_sel_g2;
                    id_d     = w_grant_idx;
                    rr_ptr_d = wrap_inc(w_grant_idx, 1);
                    cnt_d    = '0;
                    state_d  = S_ISSUE;
                end
            end

            S_ISSUE: begin
                add_en_o = 1'b1;
                cnt_d    = cnt_q + 1'b1;
                // Done is checked first so a strobe on the last allowed
                // cycle still delivers the real sum.
                if (add_done_i) begin
                    sum_d   = add_toplam_i;
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end else if (cnt_q == c_cnt_last) begin
                    sum_d   = '0;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end
            end

            S_RESP: begin
                // Enable stays high so the adder keeps its result.
                add_en_o     = 1'b1;
                res_valid_o  = 1'b1;
                res_toplam_o = sum_q;
                res_id_o     = id_q;
                res_err_o    = err_q;
                if (res_ready_i) begin
                    state_d = S_RELEASE;
                end
            end

            S_RELEASE: begin
                // Single enable-low cycle that clears the adder.
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_fp_toplama_hakem.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp_toplama_hakem
// Description : Self-checking bench for fp_toplama_hakem (N=4, b=32,
//               TIMEOUT=16). Contains a cycle-counting adder model whose done
//               delay is programmable, a directed vector table, hand-written
//               fairness / backpressure / reset sequences and a random phase
//               scored against a transaction-level round-robin model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_toplama_hakem;

    localparam int NR  = 4;
    localparam int BW  = 32;
    localparam int TO  = 16;

    logic              clk;
    logic              rst_n;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR*BW-1:0]  g1_bus;
    logic [NR*BW-1:0]  g2_bus;
    logic              add_en;
    logic [BW-1:0]     add_g1;
    logic [BW-1:0]     add_g2;
    logic              add_done;
    logic [BW-1:0]     add_sum;
    logic              res_valid;
    logic              res_ready;
    logic [BW-1:0]     res_sum;
    logic [1:0]        res_id;
    logic              res_err;
    logic              busy;

    int n_chk = 0;
    int n_err = 0;

    fp_toplama_hakem #(
        .b       (BW),
        .N       (NR),
        .IDW     (2),
        .TIMEOUT (TO)
    ) u_dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_g1_i     (g1_bus),
        .req_g2_i     (g2_bus),
        .add_en_o     (add_en),
        .add_g1_o     (add_g1),
        .add_g2_o     (add_g2),
        .add_done_i   (add_done),
        .add_toplam_i (add_sum),
        .res_valid_o  (res_valid),
        .res_ready_i  (res_ready),
        .res_toplam_o (res_sum),
        .res_id_o     (res_id),
        .res_err_o    (res_err),
        .busy_o       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Adder model: done pulses during the done_at-th consecutive enable
    // cycle (done_at=0: never). Sum is g1+g2 unless a fixed value is forced.
    int          en_cnt;
    int          done_at   = 0;
    logic        use_fixed = 1'b0;
    logic [31:0] fixed_sum = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) en_cnt <= 0;
        else        en_cnt <= add_en ? en_cnt + 1 : 0;
    end
    assign add_done = add_en && (done_at != 0) && (en_cnt == done_at - 1);
    assign add_sum  = use_fixed ? fixed_sum : (add_g1 + add_g2);

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        while (busy && n < 200) begin
            tick();
            n++;
        end
        if (busy) chk(nm, 64'(busy), 64'd0);
    endtask

    task automatic wait_res(input string nm, output int lat);
        lat = 1;
        while (!res_valid && lat < 60) begin
            tick();
            lat++;
        end
        if (!res_valid) chk(nm, 64'(res_valid), 64'd1);
    endtask

    task automatic set_slot(input int k, input logic [31:0] a, input logic [31:0] c);
        g1_bus[k*BW +: BW] = a;
        g2_bus[k*BW +: BW] = c;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    function automatic int oh2i(input logic [NR-1:0] v);
        for (int i = 0; i < NR; i++) if (v[i]) return i;
        return -1;
    endfunction

    typedef struct {
        int          id;
        logic [31:0] g1;
        logic [31:0] g2;
        int          done_at;
        logic        use_fixed;
        logic [31:0] fixed;
        logic [31:0] exp_sum;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    typedef struct {
        int          id;
        logic [31:0] sum;
        logic        err;
    } exp_t;

    task automatic run_single(input vec_t v);
        int lat;
        wait_idle("pre_idle");
        done_at   = v.done_at;
        use_fixed = v.use_fixed;
        fixed_sum = v.fixed;
        res_ready = 1'b0;
        set_slot(v.id, v.g1, v.g2);
        req_valid = 4'(1 << v.id);
        #1;
        chk("vec_ready_onehot", 64'(req_ready), 64'(1 << v.id));
        tick();
        req_valid = '0;
        wait_res("vec_res_timeout", lat);
        chk("vec_latency", 64'(lat), 64'(v.exp_lat));
        chk("vec_sum", 64'(res_sum), 64'(v.exp_sum));
        chk("vec_id", 64'(res_id), 64'(v.id));
        chk("vec_err", 64'(res_err), 64'(v.exp_err));
        chk("vec_en_resp", 64'(add_en), 64'd1);
        tick();
        chk("vec_hold_sum", 64'(res_sum), 64'(v.exp_sum));
        chk("vec_hold_err", 64'(res_err), 64'(v.exp_err));
        res_ready = 1'b1;
        tick();
        chk("vec_release_en", 64'(add_en), 64'd0);
        chk("vec_release_valid", 64'(res_valid), 64'd0);
        chk("vec_release_busy", 64'(busy), 64'd1);
        res_ready = 1'b0;
        tick();
        chk("vec_back_idle", 64'(busy), 64'd0);
        use_fixed = 1'b0;
    endtask

    vec_t vt[6];
    exp_t q[$];

    initial begin
        int lat;
        int gl[$];
        int gc[$];
        int hr;
        int cyc;
        logic [31:0] bp_sum;
        logic [NR-1:0] rv;
        logic [31:0]   dg1[NR];
        logic [31:0]   dg2[NR];
        int mptr;
        int pick;
        exp_t e;

        vt[0] = '{2, 32'h3F800000, 32'h40000000,  5, 1'b1, 32'h40400000, 32'h40400000, 1'b0,  6};
        vt[1] = '{0, 32'h00000011, 32'h00000022,  1, 1'b0, 32'h0,        32'h00000033, 1'b0,  2};
        vt[2] = '{3, 32'h12345678, 32'h11111111, 16, 1'b0, 32'h0,        32'h23456789, 1'b0, 17};
        vt[3] = '{1, 32'hAAAA0000, 32'h00005555,  0, 1'b0, 32'h0,        32'h00000000, 1'b1, 17};
        vt[4] = '{3, 32'hFFFFFFFF, 32'h00000001, 15, 1'b0, 32'h0,        32'h00000000, 1'b0, 16};
        vt[5] = '{2, 32'h00000001, 32'h00000002, 17, 1'b0, 32'h0,        32'h00000000, 1'b1, 17};

        rst_n     = 1'b0;
        req_valid = '0;
        g1_bus    = '0;
        g2_bus    = '0;
        res_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_en", 64'(add_en), 64'd0);
        chk("rst_g1", 64'(add_g1), 64'd0);
        chk("rst_valid", 64'(res_valid), 64'd0);
        chk("rst_sum", 64'(res_sum), 64'd0);
        chk("rst_ready", 64'(req_ready), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Directed vectors
        for (int i = 0; i < 6; i++) run_single(vt[i]);

        // Fairness: all valid from reset, grants 0,1,2,3,0 spaced k+3
        pulse_reset();
        for (int k = 0; k < NR; k++) set_slot(k, 32'(k * 16), 32'(k + 1));
        done_at   = 2;
        res_ready = 1'b1;
        req_valid = 4'hF;
        #1;
        hr  = 0;
        cyc = 0;
        while (gl.size() < 5 && cyc < 200) begin
            if (req_ready != 0) begin
                gl.push_back(oh2i(req_ready));
                gc.push_back(cyc);
            end
            if (add_en) hr++;
            else if (hr > 0) begin
                chk("rr_en_high_run", 64'(hr), 64'd3);
                hr = 0;
            end
            tick();
            cyc++;
        end
        chk("rr_grant_count", 64'(gl.size()), 64'd5);
        for (int i = 0; i < gl.size(); i++) begin
            chk("rr_order", 64'(gl[i]), 64'(i % NR));
            if (i > 0) chk("rr_spacing", 64'(gc[i] - gc[i-1]), 64'd5);
        end
        req_valid = '0;
        wait_idle("rr_drain");

        // Backpressure with other requesters pending
        res_ready = 1'b0;
        done_at   = 3;
        set_slot(1, 32'h01020304, 32'h10203040);
        req_valid = 4'b0010;
        tick();
        req_valid = 4'hF;
        wait_res("bp_res_timeout", lat);
        bp_sum = 32'h01020304 + 32'h10203040;
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid", 64'(res_valid), 64'd1);
            chk("bp_sum", 64'(res_sum), 64'(bp_sum));
            chk("bp_id", 64'(res_id), 64'd1);
            chk("bp_en", 64'(add_en), 64'd1);
            chk("bp_ready_zero", 64'(req_ready), 64'd0);
            chk("bp_busy", 64'(busy), 64'd1);
            tick();
        end
        req_valid = '0;
        res_ready = 1'b1;
        wait_idle("bp_drain");

        // Reset mid-ISSUE: pointer returns to 0
        res_ready = 1'b0;
        done_at   = 0;
        set_slot(2, 32'h5, 32'h6);
        req_valid = 4'b0100;
        tick();
        req_valid = '0;
        tick();
        tick();
        chk("mid_in_issue", 64'(add_en), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_en", 64'(add_en), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_g1", 64'(add_g1), 64'd0);
        chk("mid_rst_valid", 64'(res_valid), 64'd0);
        set_slot(1, 32'h100, 32'h23);
        set_slot(3, 32'h999, 32'h1);
        req_valid = 4'b1010;
        #1;
        chk("mid_rst_ready", 64'(req_ready), 64'd0);
        @(negedge clk);
        rst_n   = 1'b1;
        done_at = 2;
        #1;
        chk("mid_next_grant", 64'(req_ready), 64'b0010);
        tick();
        req_valid = '0;
        wait_res("mid_res_timeout", lat);
        chk("mid_res_id", 64'(res_id), 64'd1);
        chk("mid_res_sum", 64'(res_sum), 64'h123);
        res_ready = 1'b1;
        wait_idle("mid_drain");

        // Random phase vs transaction-level model
        pulse_reset();
        mptr = 0;
        rv   = '0;
        for (int k = 0; k < NR; k++) begin
            dg1[k] = '0;
            dg2[k] = '0;
        end
        for (int c = 0; c < 1500; c++) begin
            for (int k = 0; k < NR; k++) begin
                if (!rv[k] && $urandom_range(0, 3) == 0) begin
                    rv[k]  = 1'b1;
                    dg1[k] = $urandom;
                    dg2[k] = $urandom;
                end
                set_slot(k, dg1[k], dg2[k]);
            end
            req_valid = rv;
            res_ready = ($urandom_range(0, 2) != 0);
            #1;
            if (res_valid && res_ready) begin
                if (q.size() == 0) chk("rnd_unexpected_res", 64'(res_valid), 64'd0);
                else begin
                    e = q.pop_front();
                    chk("rnd_id", 64'(res_id), 64'(e.id));
                    chk("rnd_sum", 64'(res_sum), 64'(e.sum));
                    chk("rnd_err", 64'(res_err), 64'(e.err));
                end
            end
            if (!busy && rv != 0) begin
                pick = -1;
                for (int i = 0; i < NR; i++)
                    if (pick < 0 && rv[(mptr + i) % NR]) pick = (mptr + i) % NR;
                chk("rnd_grant", 64'(req_ready), 64'(1 << pick));
                mptr    = (pick + 1) % NR;
                done_at = $urandom_range(1, 20);
                e.id    = pick;
                e.err   = (done_at > TO);
                e.sum   = e.err ? 32'h0 : dg1[pick] + dg2[pick];
                q.push_back(e);
                rv[pick] = 1'b0;
            end
            tick();
        end
        req_valid = '0;
        res_ready = 1'b1;
        cyc = 0;
        while ((q.size() != 0 || busy) && cyc < 200) begin
            if (res_valid) begin
                e = q.pop_front();
                chk("rnd_drain_id", 64'(res_id), 64'(e.id));
                chk("rnd_drain_sum", 64'(res_sum), 64'(e.sum));
                chk("rnd_drain_err", 64'(res_err), 64'(e.err));
            end
            tick();
            cyc++;
        end
        chk("rnd_queue_empty", 64'(q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
